hub75_fb_arbiter: RTL
=====================

// Module: hub75_fb_arbiter
// PURPOSE
//  Parametrised framebuffer memory controller for the HUB75 pipeline; replaces the fixed single-SPRAM
//  arbitration inside the framebuffer top. Arbitrates row bursts between write-in and read-out engines,
//  owns buffer selection (double, optionally triple), defers frame swaps to burst boundaries and
//  aborts stuck bursts with a watchdog. Memory macro(s) sit outside; this block drives their port.
// PARAMETERS
//  ADDR_W   13   per-buffer word address width
//  DATA_W   16   memory word width
//  MASK_W   4    write-mask width (driven all-ones)
//  MAX_RUN  1024 max cycles in a RUN state before watchdog abort (>=2)
//  BUF_W    derived: 1, or 2 with HUB75_FB_TRIPLE_BUF_EN; MEM_AW = BUF_W+ADDR_W
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, synchronous, active-high
//  wi_pending   in   1        write-in engine requests a burst
//  wi_done      in   1        write-in burst complete (valid in WI_RUN)
//  wi_boot      out  1        write-in granted, boot cycle
//  wi_active    out  1        write-in granted, run phase
//  wi_addr      in   ADDR_W   write address; wi_data in DATA_W; wi_wren in 1
//  ro_pending   in   1        read-out engine requests a burst
//  ro_done      in   1        read-out burst complete (valid in RO_RUN)
//  ro_boot      out  1        read-out boot cycle; ro_active out 1 read-out run phase
//  ro_addr      in   ADDR_W   read address; ro_data out DATA_W = mem_do (1-cycle memory latency)
//  ro_frame_start in 1        display starts a new frame (used only in triple mode)
//  frame_swap   in   1        pulse: writer finished a frame
//  swap_done    out  1        pulse: buffer indices updated
//  wd_err       out  1        sticky: watchdog abort occurred (cleared only by rst)
//  mem_addr     out  MEM_AW   mem_di out DATA_W; mem_do in DATA_W; mem_wren out 1; mem_mask out MASK_W
// BEHAVIOUR
//  Reset: state IDLE_WR, all outputs 0 except mem_mask all-ones; front=0, back=1, (spare=2), swap_pend=0.
//  FSM: IDLE_WR prefers wi then ro; IDLE_RD prefers ro then wi; *_BOOT -> *_RUN after 1 cycle;
//   WI_RUN -> IDLE_RD on wi_done; RO_RUN -> IDLE_WR on ro_done (priority alternates = fairness).
//  Outputs wi_boot/wi_active/ro_boot/ro_active are registered-state decodes, one-hot or all-zero.
//  Memory mux, combinational: wi_wren ? {back,wi_addr} : {front,ro_addr}; mem_wren=wi_wren; mem_di=wi_data.
//   wi_wren wins even outside WI_RUN (writer pipeline lands one cycle after leaving RUN).
//  Watchdog: run_cnt cleared in BOOT, +1 per RUN cycle; at MAX_RUN-1 without done -> leave to the
//   same idle state as a normal finish, set wd_err. done on the final cycle counts as normal finish.
//  Swap: frame_swap sets swap_pend (repeat pulses while pending merge). Applied on a cycle in an idle
//   state with wi_wren=0 and no grant transition that cycle; swap_done pulses the following cycle.
//   frame_swap in the same cycle as application keeps swap_pend set for the next idle window.
//  rst mid-burst: state, indices, counters return to reset values next cycle; no swap_done.
// CONFIGURATION
//  HUB75_FB_TRIPLE_BUF_EN undefined: double buffer; swap exchanges front<->back; ro_frame_start ignored.
//  HUB75_FB_TRIPLE_BUF_EN defined: three buffers; swap does back<->spare, sets fresh. On ro_frame_start
//   with fresh=1 and state not RO_RUN/RO_BOOT: front<->spare, fresh=0; else retried next ro_frame_start.
//   Writer never stalls on display; display never shows partial frame.
// STRUCTURE
//  Package hub75_fb_pkg: state encodings (ST_IDLE_WR..ST_RO_RUN), buffer index width helper.
//  Sub-module hub75_fb_bufsel: holds front/back/spare/fresh, swap_pend and swap_done; FSM stays in top.
// TESTING
//  Both pending from reset -> wi_boot first; after wi_done, ro_boot granted next (alternation).
//  wi_wren=1 one cycle after wi_done, addr 0x0005 -> mem_addr={back,0x0005}, mem_wren=1, no ro grant clash.
//  frame_swap during WI_RUN -> no index change until idle; then swap_done=1, ro reads mem_addr MSB=old back.
//  Hold RO_RUN, no ro_done, MAX_RUN=16 -> exit at cycle 16, wd_err=1, state IDLE_WR, wd_err stays after.
//  Triple: swap x2 without ro_frame_start -> front unchanged; ro_frame_start -> front=latest back.
//  rst asserted in WI_RUN with swap_pend -> all outputs reset values, no swap_done pulse.

Source files
------------

// File: rtl/hub75_fb_pkg.sv
// hub75_fb_pkg: shared definitions for the HUB75 framebuffer arbiter.
//  - arbiter FSM state encoding (fb_state_e)
//  - buffer count and buffer index width (BUF_W)
// Build option: HUB75_FB_TRIPLE_BUF_EN selects three buffers (two-bit index).
package hub75_fb_pkg;

`ifdef HUB75_FB_TRIPLE_BUF_EN
   localparam int unsigned NUM_BUFS = 3;
`else
   localparam int unsigned NUM_BUFS = 2;
`endif

   // Index width needed to name one of n buffers (n is 2 or 3).
   function automatic int unsigned buf_idx_w(input int unsigned n);
      return (n > 2) ? 2 : 1;
   endfunction

   localparam int unsigned BUF_W = buf_idx_w(NUM_BUFS);

   typedef enum logic [2:0] {
      ST_IDLE_WR = 3'd0,
      ST_IDLE_RD = 3'd1,
      ST_WI_BOOT = 3'd2,
      ST_WI_RUN  = 3'd3,
      ST_RO_BOOT = 3'd4,
      ST_RO_RUN  = 3'd5
   } fb_state_e;

endpackage

// File: rtl/hub75_fb_bufsel.sv
// hub75_fb_bufsel: framebuffer index bookkeeping.
//  Holds front/back (and spare/fresh in triple mode) buffer indices plus the
//  pending-swap flag. A requested swap is applied on a cycle where the
//  arbiter reports swap_ok; swap_done pulses the cycle after.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  frame_swap        writer finished a frame (pulse)
//  swap_ok           arbiter is idle, no write landing, no grant this cycle
//  ro_frame_start    display frame start (triple mode only)
//  ro_busy           reader owns the memory (triple mode only)
//  front, back       current buffer indices
//  swap_done         pulse: indices were updated
// Build option: HUB75_FB_TRIPLE_BUF_EN enables the spare buffer.
module hub75_fb_bufsel
   import hub75_fb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_swap,
   input  logic             swap_ok,
`ifdef HUB75_FB_TRIPLE_BUF_EN
   input  logic             ro_frame_start,
   input  logic             ro_busy,
`endif
   output logic [BUF_W-1:0] front,
   output logic [BUF_W-1:0] back,
   output logic             swap_done
);

   logic [BUF_W-1:0] front_q, front_d;
   logic [BUF_W-1:0] back_q, back_d;
   logic             swap_pend_q, swap_pend_d;
   logic             swap_done_q, swap_done_d;
   logic             apply;
`ifdef HUB75_FB_TRIPLE_BUF_EN
   logic [BUF_W-1:0] spare_q, spare_d;
   logic             fresh_q, fresh_d;
`endif

   assign apply = swap_pend_q & swap_ok;

   // Next-state for indices and swap handshake.
   always_comb begin
      front_d     = front_q;
      back_d      = back_q;
      swap_done_d = apply;
      // A new request arriving while one is applied stays pending.
      swap_pend_d = frame_swap | (swap_pend_q & ~apply);
`ifdef HUB75_FB_TRIPLE_BUF_EN
      spare_d = spare_q;
      fresh_d = fresh_q;
      if (apply) begin
         back_d  = spare_q;
         spare_d = back_q;
         fresh_d = 1'b1;
      end
      // Promote the newest complete frame only between display bursts.
      if (ro_frame_start && fresh_d && !ro_busy) begin
         front_d = spare_d;
         spare_d = front_q;
         fresh_d = 1'b0;
      end
`else
      if (apply) begin
         front_d = back_q;
         back_d  = front_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         front_q     <= BUF_W'(0);
         back_q      <= BUF_W'(1);
         swap_pend_q <= 1'b0;
         swap_done_q <= 1'b0;
`ifdef HUB75_FB_TRIPLE_BUF_EN
         spare_q     <= BUF_W'(2);
         fresh_q     <= 1'b0;
`endif
      end else begin
         front_q     <= front_d;
         back_q      <= back_d;
         swap_pend_q <= swap_pend_d;
         swap_done_q <= swap_done_d;
`ifdef HUB75_FB_TRIPLE_BUF_EN
         spare_q     <= spare_d;
         fresh_q     <= fresh_d;
`endif
      end
   end

   assign front     = front_q;
   assign back      = back_q;
   assign swap_done = swap_done_q;

endmodule

// File: rtl/hub75_fb_arbiter.sv
// hub75_fb_arbiter: framebuffer memory controller for the HUB75 pipeline.
//  Alternating-priority arbitration of write-in and read-out row bursts,
//  watchdog abort of stuck bursts, frame swaps deferred to idle windows,
//  and the combinational memory port mux.
// Ports:
//  clk, rst                        clock, synchronous active-high reset
//  wi_pending/wi_done              write-in burst request / completion
//  wi_boot/wi_active               write-in grant: boot cycle / run phase
//  wi_addr/wi_data/wi_wren         write-in memory access
//  ro_pending/ro_done              read-out burst request / completion
//  ro_boot/ro_active               read-out grant: boot cycle / run phase
//  ro_addr/ro_data                 read-out access (ro_data = mem_do)
//  ro_frame_start                  display frame start (triple mode only)
//  frame_swap/swap_done            swap request pulse / swap applied pulse
//  wd_err                          sticky watchdog abort flag
//  mem_addr/mem_di/mem_do/mem_wren/mem_mask   external memory port
// Build option: HUB75_FB_TRIPLE_BUF_EN enables triple buffering.
module hub75_fb_arbiter
   import hub75_fb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MASK_W  = 4,
   parameter int unsigned MAX_RUN = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wi_pending,
   input  logic                    wi_done,
   output logic                    wi_boot,
   output logic                    wi_active,
   input  logic [ADDR_W-1:0]       wi_addr,
   input  logic [DATA_W-1:0]       wi_data,
   input  logic                    wi_wren,
   input  logic                    ro_pending,
   input  logic                    ro_done,
   output logic                    ro_boot,
   output logic                    ro_active,
   input  logic [ADDR_W-1:0]       ro_addr,
   output logic [DATA_W-1:0]       ro_data,
   input  logic                    ro_frame_start,
   input  logic                    frame_swap,
   output logic                    swap_done,
   output logic                    wd_err,
   output logic [BUF_W+ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]       mem_di,
   input  logic [DATA_W-1:0]       mem_do,
   output logic                    mem_wren,
   output logic [MASK_W-1:0]       mem_mask
);

   localparam int unsigned CNT_W = $clog2(MAX_RUN);

   fb_state_e        state_q, state_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic             wd_err_q, wd_err_d;
   logic             wi_boot_q, wi_boot_d, wi_active_q, wi_active_d;
   logic             ro_boot_q, ro_boot_d, ro_active_q, ro_active_d;
   logic             run_last, idle, swap_ok, ro_busy;
   logic [BUF_W-1:0] front, back;

   assign run_last = (run_cnt_q == CNT_W'(MAX_RUN - 1));
   assign idle     = (state_q == ST_IDLE_WR) || (state_q == ST_IDLE_RD);
   assign ro_busy  = (state_q == ST_RO_BOOT) || (state_q == ST_RO_RUN);
   // Swap only when idle, no straggling write, and no grant taken this cycle.
   assign swap_ok  = idle && !wi_wren && (state_d == state_q);

   // Arbitration FSM: the idle state remembers whose turn it is.
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      wd_err_d  = wd_err_q;
      case (state_q)
         ST_IDLE_WR: begin
            if (wi_pending)      state_d = ST_WI_BOOT;
            else if (ro_pending) state_d = ST_RO_BOOT;
         end
         ST_IDLE_RD: begin
            if (ro_pending)      state_d = ST_RO_BOOT;
            else if (wi_pending) state_d = ST_WI_BOOT;
         end
         ST_WI_BOOT: begin
            state_d   = ST_WI_RUN;
            run_cnt_d = '0;
         end
         ST_WI_RUN: begin
            if (wi_done) begin
               state_d = ST_IDLE_RD;
            end else if (run_last) begin
               state_d  = ST_IDLE_RD;
               wd_err_d = 1'b1;
            end else begin
               run_cnt_d = run_cnt_q + CNT_W'(1);
            end
         end
         ST_RO_BOOT: begin
            state_d   = ST_RO_RUN;
            run_cnt_d = '0;
         end
         ST_RO_RUN: begin
            if (ro_done) begin
               state_d = ST_IDLE_WR;
            end else if (run_last) begin
               state_d  = ST_IDLE_WR;
               wd_err_d = 1'b1;
            end else begin
               run_cnt_d = run_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE_WR;
      endcase
      wi_boot_d   = (state_d == ST_WI_BOOT);
      wi_active_d = (state_d == ST_WI_RUN);
      ro_boot_d   = (state_d == ST_RO_BOOT);
      ro_active_d = (state_d == ST_RO_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE_WR;
         run_cnt_q   <= '0;
         wd_err_q    <= 1'b0;
         wi_boot_q   <= 1'b0;
         wi_active_q <= 1'b0;
         ro_boot_q   <= 1'b0;
         ro_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         wd_err_q    <= wd_err_d;
         wi_boot_q   <= wi_boot_d;
         wi_active_q <= wi_active_d;
         ro_boot_q   <= ro_boot_d;
         ro_active_q <= ro_active_d;
      end
   end

   hub75_fb_bufsel u_bufsel (
      .clk            (clk),
      .rst            (rst),
      .frame_swap     (frame_swap),
      .swap_ok        (swap_ok),
`ifdef HUB75_FB_TRIPLE_BUF_EN
      .ro_frame_start (ro_frame_start),
      .ro_busy        (ro_busy),
`endif
      .front          (front),
      .back           (back),
      .swap_done      (swap_done)
   );

`ifndef HUB75_FB_TRIPLE_BUF_EN
   // Double buffering has no use for the display frame marker.
   logic unused_ok;
   assign unused_ok = ro_frame_start ^ ro_busy;
`endif

   // Memory mux: a landing write wins even after the writer left its run phase.
   assign mem_addr = wi_wren ? {back, wi_addr} : {front, ro_addr};
   assign mem_wren = wi_wren;
   assign mem_di   = wi_data;
   assign mem_mask = {MASK_W{1'b1}};
   assign ro_data  = mem_do;

   assign wi_boot   = wi_boot_q;
   assign wi_active = wi_active_q;
   assign ro_boot   = ro_boot_q;
   assign ro_active = ro_active_q;
   assign wd_err    = wd_err_q;

endmodule
